rv_alu_issue: RTL and testbench

Decode-to-execute issue stage for the RV32I core. It decodes a 32-bit instruction into an ALUCtrl code and the operand pair for the RVALU, then registers the result into a two-entry skid buffer that feeds the execute stage. Both sides use valid/ready handshakes. It is the producer side of the ALU's `ALUCtrl`/`a`/`b` interface.

---
 rtl/rv_alu_issue_pkg.sv | 81 ++++++++
 rtl/rv_alu_issue_if.sv | 32 +++
 rtl/rv_alu_issue_decode.sv | 122 ++++++++++++
 rtl/rv_alu_issue.sv | 88 ++++++++
 tb/tb_rv_alu_issue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_alu_issue_pkg.sv
// Shared types for the RV32I ALU issue stage: ALUCtrl encoding, opcode/funct fields, issue payload.
// Pure declarations and one decode helper; no timing or handshake of its own.
package rv_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_BLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_BGEU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_BEQ  = 4'b1100,
    ALU_BNE  = 4'b1101,
    ALU_BLT  = 4'b1110,
    ALU_BGE  = 4'b1111
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    alu_ctrl_e       alu_ctrl;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            illegal;
  } issue_t;

  // Shared by OP and OP-IMM; alt selects SUB/SRA and must be 0 for immediate arithmetic.
  function automatic alu_ctrl_e op_ctrl(input logic [2:0] f3, input logic alt);
    alu_ctrl_e r;
    case (f3)
      F3_ADD_SUB: r = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     r = ALU_SLL;
      F3_SLT:     r = ALU_SLT;
      F3_SLTU:    r = ALU_SLTU;
      F3_XOR:     r = ALU_XOR;
      F3_SRL_SRA: r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      r = ALU_OR;
      default:    r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_alu_issue_if.sv
// Issue-stage bus: input valid/ready with instruction and operands, output valid/ready with ALU payload.
// master drives instructions and consumes results; slave is the issue stage itself.
interface rv_alu_issue_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [4:0]       rd;
  logic             reg_write;
  logic             is_branch;
  logic             illegal;

  modport master (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, reg_write, is_branch, illegal
  );

  modport slave (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd, reg_write, is_branch, illegal
  );
endinterface

// File: rtl/rv_alu_issue_decode.sv
// Combinational RV32I decode into ALUCtrl plus operand pair; zero latency.
// Undecodable encodings collapse to a harmless ADD 0,0 with illegal set and no write-back.
module rv_alu_decode
  import rv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  output issue_t           issue
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt_b;
  logic        f7_base;
  logic        f7_alt;
  logic        f7_ok;
  logic        is_shift;
  logic        bad;
  issue_t      dec;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_b = {27'b0, instr[24:20]};
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  // The alternate funct7 is only meaningful for ADD/SUB and SRL/SRA.
  assign f7_ok    = f7_base || (f7_alt && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADD;
    dec.rd       = instr[11:7];
    bad          = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = rs2_data;
        dec.alu_ctrl  = op_ctrl(funct3, f7_alt);
        dec.reg_write = 1'b1;
        bad           = !f7_ok;
      end
      OPC_OP_IMM: begin
        dec.alu_a     = rs1_data;
        dec.reg_write = 1'b1;
        if (is_shift) begin
          dec.alu_b    = shamt_b;
          dec.alu_ctrl = op_ctrl(funct3, f7_alt);
          bad          = !f7_ok;
        end else begin
          dec.alu_b    = imm_i;
          dec.alu_ctrl = op_ctrl(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_a = rs1_data;
        dec.alu_b = imm_s;
      end
      OPC_BRANCH: begin
        dec.alu_a     = rs1_data;
        dec.alu_b     = rs2_data;
        dec.is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  dec.alu_ctrl = ALU_BEQ;
          F3_BNE:  dec.alu_ctrl = ALU_BNE;
          F3_BLT:  dec.alu_ctrl = ALU_BLT;
          F3_BGE:  dec.alu_ctrl = ALU_BGE;
          F3_BLTU: dec.alu_ctrl = ALU_BLTU;
          F3_BGEU: dec.alu_ctrl = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.alu_b     = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_a     = pc;
        dec.alu_b     = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU forms the link address pc+4; the jump target is handled elsewhere.
        dec.alu_a     = pc;
        dec.alu_b     = 32'd4;
        dec.reg_write = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec.alu_a     = '0;
      dec.alu_b     = '0;
      dec.alu_ctrl  = ALU_ADD;
      dec.reg_write = 1'b0;
      dec.is_branch = 1'b0;
      dec.illegal   = 1'b1;
    end
    if (dec.rd == 5'd0) begin
      dec.reg_write = 1'b0;
    end
    issue = dec;
  end

endmodule

// File: rtl/rv_alu_issue.sv
// Decode-to-execute issue stage: decode then a two-entry skid buffer; 1-cycle latency, full throughput.
// in_ready comes only from skid occupancy, so upstream never sees a combinational path from out_ready.
module rv_alu_issue
  import rv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  rv_alu_issue_if.slave bus
);

  issue_t dec;
  issue_t out_d;
  issue_t out_q;
  issue_t skid_d;
  issue_t skid_q;
  logic   out_vld_d;
  logic   out_vld_q;
  logic   skid_vld_d;
  logic   skid_vld_q;
  logic   in_fire;
  logic   out_fire;

  rv_alu_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .instr    (bus.instr),
    .pc       (bus.pc),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .issue    (dec)
  );

  assign in_fire  = bus.in_valid && !skid_vld_q;
  assign out_fire = out_vld_q && bus.out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_fire) begin
      // Output slot frees up: the older skid entry always wins over new input to keep FIFO order.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready  = !skid_vld_q;
  assign bus.out_valid = out_vld_q;
  assign bus.alu_a     = out_q.alu_a;
  assign bus.alu_b     = out_q.alu_b;
  assign bus.alu_ctrl  = out_q.alu_ctrl;
  assign bus.rd        = out_q.rd;
  assign bus.reg_write = out_q.reg_write;
  assign bus.is_branch = out_q.is_branch;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed bench for rv_alu_issue: decode vectors, throughput, backpressure, flush and reset.
module tb_rv_alu_issue;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rv_alu_issue_if #(.WIDTH(32)) bus();

  rv_alu_issue #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [75:0] exp;
  } vec_t;

  // {alu_a, alu_b, alu_ctrl, rd, reg_write, is_branch, illegal}
  function automatic logic [75:0] snap();
    return {bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rd, bus.reg_write, bus.is_branch, bus.illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.pc       = p;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instr     = 32'h0;
    bus.pc        = 32'h0;
    bus.rs1_data  = 32'h0;
    bus.rs2_data  = 32'h0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (snap() !== 76'h0) begin failures++; $display("FAIL reset_payload: got %h expected 0", snap()); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    vec_t v[$];
    v.push_back('{"add",       32'h002081B3, 32'h0,   32'd100,       32'd50, {32'd100, 32'd50, 4'b0010, 5'd3, 3'b100}});
    v.push_back('{"sub",       32'h402081B3, 32'h0,   32'd100,       32'd50, {32'd100, 32'd50, 4'b0110, 5'd3, 3'b100}});
    v.push_back('{"srai",      32'h4040D193, 32'h0,   32'h80000000,  32'd9,  {32'h80000000, 32'd4, 4'b1011, 5'd3, 3'b100}});
    v.push_back('{"bltu",      32'h0020E063, 32'h0,   32'd5,         32'd7,  {32'd5, 32'd7, 4'b0101, 5'd0, 3'b010}});
    v.push_back('{"beq",       32'h00208063, 32'h0,   32'd8,         32'd8,  {32'd8, 32'd8, 4'b1100, 5'd0, 3'b010}});
    v.push_back('{"auipc",     32'h12345297, 32'h100, 32'd77,        32'd88, {32'h100, 32'h12345000, 4'b0010, 5'd5, 3'b100}});
    v.push_back('{"lui",       32'hABCDE3B7, 32'h40,  32'd55,        32'd66, {32'h0, 32'hABCDE000, 4'b0010, 5'd7, 3'b100}});
    v.push_back('{"opc_7f",    32'h0000007F, 32'h80,  32'd123,       32'd45, {32'h0, 32'h0, 4'b0010, 5'd0, 3'b001}});
    v.push_back('{"addi_neg",  32'hFFF10093, 32'h0,   32'd10,        32'd3,  {32'd10, 32'hFFFFFFFF, 4'b0010, 5'd1, 3'b100}});
    v.push_back('{"add_x0",    32'h00208033, 32'h0,   32'd1,         32'd2,  {32'd1, 32'd2, 4'b0010, 5'd0, 3'b000}});
    v.push_back('{"bad_f7",    32'h022081B3, 32'h0,   32'd4,         32'd6,  {32'h0, 32'h0, 4'b0010, 5'd3, 3'b001}});
    v.push_back('{"br_f3_010", 32'h0020A063, 32'h0,   32'd4,         32'd6,  {32'h0, 32'h0, 4'b0010, 5'd0, 3'b001}});
    v.push_back('{"sw",        32'h0020A423, 32'h0,   32'h1000,      32'd9,  {32'h1000, 32'd8, 4'b0010, 5'd8, 3'b000}});
    v.push_back('{"jal",       32'h000000EF, 32'h200, 32'd3,         32'd3,  {32'h200, 32'd4, 4'b0010, 5'd1, 3'b100}});
    v.push_back('{"slli_alt",  32'h40109193, 32'h0,   32'd3,         32'd3,  {32'h0, 32'h0, 4'b0010, 5'd3, 3'b001}});
    v.push_back('{"sltiu",     32'h0050B193, 32'h0,   32'd2,         32'd3,  {32'd2, 32'd5, 4'b0011, 5'd3, 3'b100}});
    bus.out_ready = 1'b1;
    foreach (v[k]) begin
      drive(v[k].instr, v[k].pc, v[k].rs1, v[k].rs2);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid: got %b expected 1", v[k].name, bus.out_valid); end
      checks++; if (snap() !== v[k].exp) begin failures++; $display("FAIL %s_payload: got %h expected %h", v[k].name, snap(), v[k].exp); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL decode_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(32'h002081B3, 32'h0, k, 32'd0);
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'(k) || bus.in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_%0d: got valid=%b a=%0d in_ready=%b expected 1 %0d 1", k, bus.out_valid, bus.alu_a, bus.in_ready, k);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd10, 32'd0);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_a !== 32'd10 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_i0: got valid=%b a=%0d in_ready=%b expected 1 10 1", bus.out_valid, bus.alu_a, bus.in_ready);
    end
    drive(32'h002081B3, 32'h0, 32'd11, 32'd0);
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.alu_a !== 32'd10) begin
      failures++; $display("FAIL bp_i1_skid: got in_ready=%b a=%0d expected 0 10", bus.in_ready, bus.alu_a);
    end
    drive(32'h002081B3, 32'h0, 32'd12, 32'd0);
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.alu_a !== 32'd10 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_hold: got in_ready=%b a=%0d valid=%b expected 0 10 1", bus.in_ready, bus.alu_a, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.alu_a !== 32'd11 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_out_i1: got a=%0d valid=%b in_ready=%b expected 11 1 1", bus.alu_a, bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.alu_a !== 32'd12 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_out_i2: got a=%0d valid=%b expected 12 1", bus.alu_a, bus.out_valid);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd20, 32'd0);
    tick();
    drive(32'h002081B3, 32'h0, 32'd21, 32'd0);
    tick();
    drive(32'h002081B3, 32'h0, 32'd22, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_full: got valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    drive(32'h002081B3, 32'h0, 32'd30, 32'd0);
    tick();
    drive(32'h002081B3, 32'h0, 32'd31, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_with_input: got valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_input_dropped: got valid=%b a=%0d expected valid 0", bus.out_valid, bus.alu_a); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    drive(32'h402081B3, 32'h0, 32'd40, 32'd1);
    tick();
    drive(32'h402081B3, 32'h0, 32'd41, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ctrl: got valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    checks++; if (snap() !== 76'h0) begin failures++; $display("FAIL rst_mid_payload: got %h expected 0", snap()); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_empty: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    drain();
    test_back_to_back();
    drain();
    test_backpressure();
    drain();
    test_flush();
    drain();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
